// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports, one writeback port, one reserve port.
interface register_file_if #(
  parameter int unsigned size = 32
);
  localparam int unsigned addr_w = 5;

  logic [addr_w-1:0] read_addr_a;
  logic [size-1:0]   read_data_a;
  logic              read_busy_a;

  logic [addr_w-1:0] read_addr_b;
  logic [size-1:0]   read_data_b;
  logic              read_busy_b;

  logic              write_enable;
  logic [addr_w-1:0] write_addr;
  logic [size-1:0]   write_data;

  logic              reserve_enable;
  logic [addr_w-1:0] reserve_addr;

  // Pipeline side: issues addresses, writebacks and reservations.
  modport master (
    output read_addr_a, read_addr_b,
    output write_enable, write_addr, write_data,
    output reserve_enable, reserve_addr,
    input  read_data_a, read_busy_a, read_data_b, read_busy_b
  );

  // Register-file side.
  modport slave (
    input  read_addr_a, read_addr_b,
    input  write_enable, write_addr, write_data,
    input  reserve_enable, reserve_addr,
    output read_data_a, read_busy_a, read_data_b, read_busy_b
  );
endinterface

// File: rtl/register_file.sv
// 32-entry register file with x0 hardwired to zero, write-through bypass on
// both read ports, and a per-register busy scoreboard for hazard stalls.
module register_file #(
  parameter int unsigned size = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  register_file_if.slave     bus
);
  localparam int unsigned nregs  = 32;
  localparam int unsigned addr_w = 5;

  logic [size-1:0]  regs [nregs];
  logic [nregs-1:0] busy;

  logic write_hit;
  logic reserve_hit;
  logic hit_a;
  logic hit_b;

  // Writeback/reserve strobes qualified against x0, and per-port bypass matches.
  always_comb begin
    write_hit   = bus.write_enable && (bus.write_addr != addr_w'(0));
    reserve_hit = bus.reserve_enable && (bus.reserve_addr != addr_w'(0));
    hit_a       = write_hit && (bus.write_addr == bus.read_addr_a);
    hit_b       = write_hit && (bus.write_addr == bus.read_addr_b);
  end

  // Register storage; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(nregs); i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // Scoreboard: writeback clears, reserve sets; the later assignment lets set win.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (write_hit) begin
        busy[bus.write_addr] <= 1'b0;
      end
      if (reserve_hit) begin
        busy[bus.reserve_addr] <= 1'b1;
      end
    end
  end

  // Read port A: x0 and reset force zero; a same-cycle writeback bypasses and releases busy.
  always_comb begin
    bus.read_data_a = '0;
    bus.read_busy_a = 1'b0;
    if (reset_n && (bus.read_addr_a != addr_w'(0))) begin
      bus.read_data_a = hit_a ? bus.write_data : regs[bus.read_addr_a];
      bus.read_busy_a = busy[bus.read_addr_a] && !hit_a;
    end
  end

  // Read port B: same behaviour as port A, fully independent.
  always_comb begin
    bus.read_data_b = '0;
    bus.read_busy_b = 1'b0;
    if (reset_n && (bus.read_addr_b != addr_w'(0))) begin
      bus.read_data_b = hit_b ? bus.write_data : regs[bus.read_addr_b];
      bus.read_busy_b = busy[bus.read_addr_b] && !hit_b;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference.
module tb_register_file;
  localparam int unsigned size = 32;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  register_file_if #(.size(size)) bus ();

  register_file #(.size(size)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [size-1:0] ref_regs [32];
  logic            ref_busy [32];
  int errors = 0;
  int checks = 0;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [size-1:0] observed,
                       input logic [size-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [size-1:0] ref_data(input logic [4:0] a);
    if (!reset_n || a == 5'd0) return '0;
    if (bus.write_enable && bus.write_addr == a) return bus.write_data;
    return ref_regs[a];
  endfunction

  function automatic logic ref_busy_of(input logic [4:0] a);
    if (!reset_n || a == 5'd0) return 1'b0;
    return ref_busy[a] && !(bus.write_enable && bus.write_addr == a);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = '0;
      ref_busy[i] = 1'b0;
    end
  endtask

  // Model of what the clock edge does to architectural state.
  task automatic ref_edge();
    if (!reset_n) begin
      ref_clear();
    end else begin
      if (bus.write_enable && bus.write_addr != 5'd0) begin
        ref_regs[bus.write_addr] = bus.write_data;
        ref_busy[bus.write_addr] = 1'b0;
      end
      if (bus.reserve_enable && bus.reserve_addr != 5'd0)
        ref_busy[bus.reserve_addr] = 1'b1;
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_data_a"}, bus.read_data_a, ref_data(bus.read_addr_a));
    check({tag, "_busy_a"}, size'(bus.read_busy_a), size'(ref_busy_of(bus.read_addr_a)));
    check({tag, "_data_b"}, bus.read_data_b, ref_data(bus.read_addr_b));
    check({tag, "_busy_b"}, size'(bus.read_busy_b), size'(ref_busy_of(bus.read_addr_b)));
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic clock_edge();
    @(posedge clock);
    ref_edge();
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [size-1:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a, input logic [4:0] b);
    bus.write_enable   = we;
    bus.write_addr     = wa;
    bus.write_data     = wd;
    bus.reserve_enable = re;
    bus.reserve_addr   = ra;
    bus.read_addr_a    = a;
    bus.read_addr_b    = b;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset_n = 1'b0;
    ref_clear();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd5, 5'd31);
    #1;
    check_reads("in_reset");
    clock_edge();
    clock_edge();
    @(negedge clock);
    reset_n = 1'b1;
    clock_edge();

    // Reset values on x5 / x31.
    settle();
    check("rst_x5_data",  bus.read_data_a, 32'h0);
    check("rst_x31_data", bus.read_data_b, 32'h0);
    check("rst_x5_busy",  size'(bus.read_busy_a), '0);
    check("rst_x31_busy", size'(bus.read_busy_b), '0);
    clock_edge();

    // Write then read on both ports.
    drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    settle(); check_reads("wr_x7");
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd7);
    settle();
    check("rd_x7_a", bus.read_data_a, 32'hDEADBEEF);
    check("rd_x7_b", bus.read_data_b, 32'hDEADBEEF);
    clock_edge();

    // Same-cycle bypass.
    drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd7);
    settle();
    check("bypass_x3_a", bus.read_data_a, 32'h12345678);
    check_reads("bypass");
    clock_edge();

    // x0 ignores write and reserve.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    check("x0_bypass_data", bus.read_data_a, 32'h0);
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    check("x0_data", bus.read_data_a, 32'h0);
    check("x0_busy", size'(bus.read_busy_b), '0);
    clock_edge();

    // Scoreboard sequence on x9.
    drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    settle();
    check("rsv_not_comb", size'(bus.read_busy_a), '0);
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    check("rsv_x9_busy", size'(bus.read_busy_a), 32'd1);
    clock_edge();
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    check("wb_x9_busy", size'(bus.read_busy_a), '0);
    check("wb_x9_data", bus.read_data_a, 32'h55);
    clock_edge();
    drive(1'b1, 5'd9, 32'h66, 1'b1, 5'd9, 5'd9, 5'd9);
    settle(); check_reads("rsv_wr_same");
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    check("set_wins_busy", size'(bus.read_busy_a), 32'd1);
    check("set_wins_data", bus.read_data_b, 32'h66);
    clock_edge();
    // Re-reserve of a busy register, then one write clears it.
    drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    clock_edge();
    drive(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 5'd9, 5'd9);
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    check("single_clear", size'(bus.read_busy_a), '0);
    clock_edge();

    // Asynchronous reset mid-cycle.
    drive(1'b1, 5'd4, 32'hA5, 1'b1, 5'd4, 5'd4, 5'd4);
    clock_edge();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd4, 5'd4);
    #1;
    check("pre_rst_x4_data", bus.read_data_a, 32'hA5);
    check("pre_rst_x4_busy", size'(bus.read_busy_a), 32'd1);
    reset_n = 1'b0;
    ref_clear();
    #1;
    check("async_x4_data", bus.read_data_a, 32'h0);
    check("async_x4_busy", size'(bus.read_busy_b), '0);
    // Writes and reserves are ignored while held in reset.
    drive(1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 5'd4, 5'd5);
    clock_edge();
    clock_edge();
    settle(); check_reads("held_rst");
    reset_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd4, 5'd4);
    #1; check_reads("post_rst");
    clock_edge();

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), size'($urandom()),
            1'($urandom_range(0, 2) == 0), rand_addr(), rand_addr(), rand_addr());
      settle();
      check_reads("rand");
      if ($urandom_range(0, 63) == 0) begin
        reset_n = 1'b0;
        ref_clear();
        #1;
        check_reads("rand_rst");
        reset_n = 1'b1;
      end
      clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have one parameter: size, default 32, data width in bits of every register and data port.
REQ-002 The module SHALL hold exactly 32 registers x0..x31, addressed by 5-bit addresses.
REQ-003 The module SHALL have a port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have a port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have a port read_addr_a, input, 5 bits, the read port A address.
REQ-006 The module SHALL have a port read_data_a, output, size bits, the read port A data.
REQ-007 The module SHALL have a port read_busy_a, output, 1 bit, asserted when the register addressed by read port A has a pending write.
REQ-008 The module SHALL have the ports read_addr_b, read_data_b and read_busy_b, identical to port A and fully independent of it.
REQ-009 The module SHALL have a port write_enable, input, 1 bit, the writeback strobe.
REQ-010 The module SHALL have a port write_addr, input, 5 bits, the writeback destination.
REQ-011 The module SHALL have a port write_data, input, size bits, the writeback value.
REQ-012 The module SHALL have a port reserve_enable, input, 1 bit, which marks a destination as pending, issued by the decode stage.
REQ-013 The module SHALL have a port reserve_addr, input, 5 bits, the destination to mark as pending.

Function
REQ-014 Reads SHALL be combinational: read_data and read_busy depend only on the current address, the current write inputs and the registered state; there is zero cycle latency.
REQ-015 When write_enable=1 and write_addr!=0, the register file SHALL store write_data into register write_addr at the rising clock edge.
REQ-016 Writes to x0 SHALL be ignored; reads of x0 SHALL return 0 with busy=0, regardless of any write or reserve to x0.
REQ-017 Write-through bypass: when write_enable=1, write_addr==read_addr and the address is nonzero, read_data SHALL equal write_data in that same cycle.
REQ-018 The scoreboard SHALL be one busy bit per register (x1..x31); a reserve with reserve_enable=1 and reserve_addr!=0 SHALL set busy[reserve_addr] at the clock edge.
REQ-019 A write with write_enable=1 and write_addr!=0 SHALL clear busy[write_addr] at the clock edge.
REQ-020 When reserve and write target the same address in the same cycle, set SHALL win: busy=1 after the edge, and the data is still written.
REQ-021 When reserve and write target different addresses in the same cycle, both updates SHALL take effect independently.
REQ-022 read_busy SHALL equal busy[addr] AND NOT (write_enable=1 AND write_addr==addr), so that a same-cycle writeback releases the stall together with the bypass.
REQ-023 A reserve SHALL be visible on read_busy only from the cycle after its edge, never combinationally.
REQ-024 A reserve of an already-busy register SHALL keep it busy: there is no counting, and a single write clears it.
REQ-025 Out-of-range behaviour SHALL NOT exist: all 5-bit addresses are valid, and no error output is provided.

Reset
REQ-026 While reset_n=0, asynchronously and independent of clock, all 32 registers SHALL read 0 and all busy bits SHALL be 0.
REQ-027 While reset_n=0, write and reserve inputs SHALL be ignored, including a clock edge coincident with reset assertion.
REQ-028 On the first rising clock edge after reset_n deasserts, normal write and reserve operation SHALL resume.
REQ-029 A reset mid-operation SHALL discard all pending reservations: busy=0 for every register.

Verification
REQ-030 The bench SHALL cover reset then reads: read x5 and x31 -> data 0 and busy 0 on both ports.
REQ-031 The bench SHALL cover write then read: write x7=0xDEADBEEF, then next cycle read_addr_a=7 and read_addr_b=7 -> both return 0xDEADBEEF.
REQ-032 The bench SHALL cover the bypass case: write x3=0x12345678 while read_addr_a=3 in the same cycle -> read_data_a=0x12345678 before the edge.
REQ-033 The bench SHALL cover x0 behaviour: write x0=0xFFFFFFFF and reserve x0 -> read x0 gives 0 with busy 0.
REQ-034 The bench SHALL cover the scoreboard sequence: reserve x9 -> next cycle busy_a=1; write x9=0x55 -> busy_a=0 and data=0x55 in that cycle; reserve and write x9 in the same cycle -> busy=1 after the edge and data updated.
REQ-035 The bench SHALL cover asynchronous reset: reserve x4 and write x4=0xA5, then pulse reset_n low between clock edges -> read x4 immediately gives 0 with busy 0.
